// File: rtl/trg_pattern_gen_pkg.sv
// Shared types for the trigger pattern generator.
// Holds the state encoding and the minimum legal period.
package trg_pattern_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/trg_pattern_gen_counter.sv
// Width-parameterised phase counter with clear and enable.
// Ports: clk, rst (sync, active-low), clr, en -> q.
module trg_pattern_gen_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/trg_pattern_gen.sv
// Programmable periodic trigger generator with burst/stop control.
// Ports: clk, rst, cfg_period/high/burst, start, stop ->
//   trg_out, sync_out, busy, done, pulse_cnt.
module trg_pattern_gen
  import trg_pattern_gen_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_WIDTH-1:0]   cfg_period,
  input  logic [CNT_WIDTH-1:0]   cfg_high,
  input  logic [BURST_WIDTH-1:0] cfg_burst,
  input  logic                   start,
  input  logic                   stop,
  output logic                   trg_out,
  output logic                   sync_out,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_WIDTH-1:0] pulse_cnt
);

  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MIN_P =
    CNT_WIDTH'(MIN_PERIOD);
  localparam logic [BURST_WIDTH-1:0] B_ONE =
    BURST_WIDTH'(1);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   per_l;
  logic [CNT_WIDTH-1:0]   high_l;
  logic [BURST_WIDTH-1:0] burst_l;
  logic                   stop_pend;

  logic [CNT_WIDTH-1:0]   phase;
  logic [CNT_WIDTH-1:0]   phase_nx;
  logic [CNT_WIDTH-1:0]   per_c;
  logic [CNT_WIDTH-1:0]   high_c;
  logic [BURST_WIDTH-1:0] cnt_inc;
  logic                   end_per;
  logic                   fin;
  logic                   ph_clr;
  logic                   ph_en;

  // Clamped config as it would be latched on start.
  always_comb begin
    per_c  = (cfg_period < MIN_P) ? MIN_P : cfg_period;
    high_c = (cfg_high > per_c - ONE) ?
             per_c - ONE : cfg_high;
  end

  always_comb begin
    end_per  = (state == RUN) && (phase == per_l - ONE);
    phase_nx = phase + ONE;
    cnt_inc  = (pulse_cnt == '1) ?
               pulse_cnt : pulse_cnt + B_ONE;
    fin      = ((burst_l != '0) && (cnt_inc == burst_l))
               || stop_pend || stop;
    ph_clr   = (state == IDLE) || end_per;
    ph_en    = (state == RUN);
  end

  trg_pattern_gen_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_phase (
    .clk (clk),
    .rst (rst),
    .clr (ph_clr),
    .en  (ph_en),
    .q   (phase)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      per_l     <= MIN_P;
      high_l    <= '0;
      burst_l   <= '0;
      stop_pend <= 1'b0;
      trg_out   <= 1'b0;
      sync_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          trg_out   <= 1'b0;
          sync_out  <= 1'b0;
          busy      <= 1'b0;
          stop_pend <= 1'b0;
          // Stop has priority over a simultaneous start.
          if (start && !stop) begin
            per_l     <= per_c;
            high_l    <= high_c;
            burst_l   <= cfg_burst;
            pulse_cnt <= '0;
            state     <= RUN;
            busy      <= 1'b1;
            sync_out  <= 1'b1;
            trg_out   <= (high_c != '0);
          end
        end
        RUN: begin
          if (end_per) begin
            pulse_cnt <= cnt_inc;
            if (fin) begin
              state     <= IDLE;
              done      <= 1'b1;
              busy      <= 1'b0;
              trg_out   <= 1'b0;
              sync_out  <= 1'b0;
              stop_pend <= 1'b0;
            end else begin
              sync_out <= 1'b1;
              trg_out  <= (high_l != '0);
            end
          end else begin
            sync_out <= 1'b0;
            trg_out  <= (phase_nx < high_l);
            if (stop) begin
              stop_pend <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trg_pattern_gen.sv
// Scoreboard bench for trg_pattern_gen.
// Stimulus queues per-cycle expectations; a monitor compares.
module tb_trg_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_high = '0;
  logic [7:0]  cfg_burst = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        trg_out;
  logic        sync_out;
  logic        busy;
  logic        done;
  logic [7:0]  pulse_cnt;

  typedef struct packed {
    logic       trg;
    logic       sync;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [7:0] last_cnt = '0;

  trg_pattern_gen #(
    .CNT_WIDTH(16),
    .BURST_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_period(cfg_period),
    .cfg_high  (cfg_high),
    .cfg_burst (cfg_burst),
    .start     (start),
    .stop      (stop),
    .trg_out   (trg_out),
    .sync_out  (sync_out),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per clock, sampled after the edge.
  always @(posedge clk) begin
    exp_t e;
    exp_t g;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {trg_out, sync_out, busy, done, pulse_cnt};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cyc%0d outputs: got trg=%0b sync=%0b busy=%0b done=%0b cnt=%0d need trg=%0b sync=%0b busy=%0b done=%0b cnt=%0d",
                 cyc, g.trg, g.sync, g.busy, g.done, g.cnt,
                 e.trg, e.sync, e.busy, e.done, e.cnt);
      end
    end
  end

  task automatic step(input logic s, input logic st,
                      input logic r, input exp_t e);
    @(negedge clk);
    start = s;
    stop  = st;
    rst   = r;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic s,
                      input logic st, input logic r);
    exp_t e;
    if (!r) last_cnt = '0;
    e = '0;
    e.cnt = last_cnt;
    for (int k = 0; k < n; k++) step(s, st, r, e);
  endtask

  // stop_i / rst_i: cycle index after start at which the
  // input is applied (0 = never). exp_cnt: hand value at done.
  task automatic run(input int per, input int hi,
                     input int bu, input int stop_i,
                     input int rst_i, input logic [7:0] exp_cnt);
    int   pl;
    int   hl;
    int   ph;
    int   cnt;
    bit   pend;
    logic sv;
    exp_t e;
    pl = (per < 2) ? 2 : per;
    hl = (hi > pl - 1) ? pl - 1 : hi;
    cfg_period = 16'(per);
    cfg_high   = 16'(hi);
    cfg_burst  = 8'(bu);
    ph   = 0;
    cnt  = 0;
    pend = 0;
    e = '0;
    e.trg  = (hl > 0);
    e.sync = 1'b1;
    e.busy = 1'b1;
    step(1'b1, 1'b0, 1'b1, e);
    for (int i = 1; i < 5000; i++) begin
      sv = (i == stop_i);
      if (i == rst_i) begin
        step(1'b0, 1'b0, 1'b0, '0);
        last_cnt = '0;
        return;
      end
      if (ph == pl - 1) begin
        cnt = (cnt < 255) ? cnt + 1 : 255;
        if ((bu != 0 && cnt == bu) || pend || sv) begin
          e = '0;
          e.done = 1'b1;
          e.cnt  = exp_cnt;
          step(1'b0, sv, 1'b1, e);
          last_cnt = exp_cnt;
          return;
        end
        ph = 0;
      end else begin
        ph++;
        if (sv) pend = 1;
      end
      e = '0;
      e.trg  = (ph < hl);
      e.sync = (ph == 0);
      e.busy = 1'b1;
      e.cnt  = 8'(cnt);
      step((i == 5), sv, 1'b1, e);
      if (i == 1) begin
        cfg_period = 16'd3;
        cfg_high   = 16'd0;
        cfg_burst  = 8'd1;
      end
    end
  endtask

  initial begin
    idle(3, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0, 1'b1);
    run(10, 3, 4, 0, 0, 8'd4);
    idle(3, 1'b0, 1'b0, 1'b1);
    run(0, 5, 2, 0, 0, 8'd2);
    idle(2, 1'b0, 1'b0, 1'b1);
    run(8, 4, 0, 19, 0, 8'd3);
    idle(2, 1'b0, 1'b0, 1'b1);
    cfg_period = 16'd10;
    cfg_high   = 16'd3;
    idle(4, 1'b1, 1'b1, 1'b1);
    run(10, 3, 4, 0, 2, 8'd0);
    idle(3, 1'b0, 1'b0, 1'b1);
    run(10, 3, 4, 0, 0, 8'd4);
    idle(2, 1'b0, 1'b0, 1'b1);
    run(4, 0, 2, 0, 0, 8'd2);
    idle(2, 1'b0, 1'b0, 1'b1);
    run(2, 1, 0, 600, 0, 8'd255);
    idle(3, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending need 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/trg_pattern_gen.md
Name: trg_pattern_gen

Overview:
- Programmable test-trigger generator driving the di_xx inputs of the IO-delay stage, in place of the free-running counter MSB.
- Produces a periodic pulse train with software-set period, high time and burst length.
- Configured and started from MicroBlaze GPIO bits.
- Runs in the 200 MHz IO-reference clock domain; also emits a per-period sync strobe for ILA triggering.

Parameters:
- CNT_WIDTH, 16: width of period/high-time fields and phase counter.
- BURST_WIDTH, 8: width of burst-length field and pulse counter.

Ports:
- clk, input, 1: 200 MHz IO-reference clock; all logic on rising edge.
- rst, input, 1: synchronous, active-low reset.
- cfg_period, input, CNT_WIDTH: pulse period in clk cycles.
- cfg_high, input, CNT_WIDTH: high time in clk cycles.
- cfg_burst, input, BURST_WIDTH: pulses per run; 0 = continuous.
- start, input, 1: level-sampled start request.
- stop, input, 1: level-sampled graceful stop request.
- trg_out, output, 1: registered trigger pulse to IO-delay inputs.
- sync_out, output, 1: one-cycle strobe coincident with first cycle of each period.
- busy, output, 1: high while running.
- done, output, 1: one-cycle pulse on return to idle.
- pulse_cnt, output, BURST_WIDTH: completed periods since last start; saturates at all-ones.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; trg_out, sync_out, busy, done = 0; pulse_cnt=0; stop_pend=0.
  - Reset overrides everything, including mid-run.
- States: IDLE, RUN. All outputs are registered.
- IDLE:
  - trg_out=0, busy=0.
  - start=1 and stop=0 at edge T: latch config, clear pulse_cnt, go to RUN.
  - start=1 and stop=1 together: stop wins, start ignored.
  - Config changes while in RUN are ignored until the next start.
- Config latch rules:
  - per_l = max(cfg_period, 2).
  - high_l = min(cfg_high, per_l-1).
  - high_l=0 is legal: trg_out stays 0, but periods, sync_out and pulse_cnt run normally.
- RUN timing:
  - At T+1: phase=0, busy=1, sync_out=1, trg_out=(high_l>0).
  - Each later cycle: phase+1; trg_out=(phase<high_l); sync_out=(phase==0).
- End of period (cycle with phase==per_l-1), next edge:
  - pulse_cnt+1, saturating.
  - Finish if (burst_l!=0 and pulse_cnt+1==burst_l) or stop_pend or stop=1.
  - Finish: go to IDLE; done=1 for one cycle; busy=0, trg_out=0, sync_out=0.
  - Otherwise: phase=0, next period starts with no gap.
- Stop handling:
  - stop=1 sampled in RUN sets stop_pend; the current period always completes, so no runt pulses.
  - stop_pend is cleared on entry to IDLE.
  - start while in RUN is ignored.
- Continuous mode (burst_l=0): runs until stop; pulse_cnt saturates at 2^BURST_WIDTH-1 and does not wrap.
- Latency and duty:
  - start to first trg_out high = 1 cycle.
  - Duty = high_l/per_l exactly; period is exact with no drift.

Decomposition:
- Shared header trg_pattern_gen_defs.vh holds state encodings (IDLE=1'b0, RUN=1'b1) and the minimum-period constant (2).
- No sub-module is required. The phase counter may reuse the existing width-parameterised COUNTER, with clr driven by end-of-period/idle and en driven by RUN.

Test Plan:
- Burst: period=10, high=3, burst=4, start pulse at T → trg_out high T+1..T+3, T+11..T+13, T+21..T+23, T+31..T+33; done at T+41; pulse_cnt=4; busy low from T+41.
- Clamping: period=0, high=5, burst=2 → per_l=2, high_l=1; trg_out toggles 1,0,1,0 from T+1; done at T+5.
- Graceful stop: continuous, period=8, high=4; stop asserted at phase 2 of the 3rd period → that period completes; done one cycle after its phase 7; pulse_cnt=3; no runt pulse.
- Start and stop together in IDLE → stays IDLE; busy=0; no trg_out activity.
- Mid-run reset: rst=0 during the high phase → next edge trg_out=0, busy=0, pulse_cnt=0, done=0. After release, a new start behaves as in the burst scenario.
- Saturation: BURST_WIDTH=8, continuous, period=2, run 300 periods → pulse_cnt holds 255; trg_out keeps toggling.
